hazard_scoreboard_unit: RTL and testbench

//  Parametrised hazard and forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/hazard_scoreboard_unit.sv | 209 ++++++++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// Hazard and forwarding controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Each architectural register has a small pending-write counter. In-flight
// producers increment it at issue from ID and decrement it at retirement in WB.
// In forwarding mode, only the load-use case stalls. Without forwarding, a
// reader stalls until its producer reaches WB.
// The unit also drives branch/jump flushes, a saturating stall-cycle counter
// and a sticky error for a WB write that retires with nothing pending.

module hazard_scoreboard_unit #(
    parameter int NREG      = 32,
    parameter int REGW      = 5,
    parameter int CNTW      = 16,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            fwd_en_i,
    input  logic            id_valid_i,
    input  logic [REGW-1:0] id_rs_i,
    input  logic [REGW-1:0] id_rt_i,
    input  logic            id_use_rs_i,
    input  logic            id_use_rt_i,
    input  logic            id_regwrite_i,
    input  logic [REGW-1:0] id_dst_i,
    input  logic            id_jump_i,
    input  logic [REGW-1:0] ex_rs_i,
    input  logic [REGW-1:0] ex_rt_i,
    input  logic            ex_memread_i,
    input  logic [REGW-1:0] ex_dst_i,
    input  logic            ex_branch_tk_i,
    input  logic            mem_regwrite_i,
    input  logic [REGW-1:0] mem_dst_i,
    input  logic            wb_regwrite_i,
    input  logic [REGW-1:0] wb_dst_i,
    output logic            pc_write_o,
    output logic            if_id_we_o,
    output logic            if_id_flush_o,
    output logic            id_ex_flush_o,
    output logic [1:0]      fwd_a_o,
    output logic [1:0]      fwd_b_o,
    output logic [CNTW-1:0] stall_cnt_o,
    output logic            sb_err_o
);

    localparam logic [CNTW-1:0] STALL_MAX = {CNTW{1'b1}};

    // Operand select encodings on the EX-stage ALU mux
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Pending-write count per register. Entry 0 is tied to zero because r0 is never a hazard.
    logic [1:0]      cnt [NREG];

    logic            haz_rs;
    logic            haz_rt;
    logic            stall;
    logic            issue;
    logic            retire;

    logic [CNTW-1:0] stall_cnt_q;
    logic [CNTW-1:0] stall_cnt_d;
    logic            sb_err_q;
    logic            sb_err_d;

    // Detect a RAW hazard on each ID source operand, using the rule for the current mode
    always_comb begin
        logic lu_rs;
        logic lu_rt;
        logic nf_rs;
        logic nf_rt;

        // Forwarding mode: only a load sitting in EX cannot be bypassed in time
        lu_rs = ex_memread_i && (ex_dst_i == id_rs_i);
        lu_rt = ex_memread_i && (ex_dst_i == id_rt_i);

        // No-forward mode: any pending write blocks the read. The exception is
        // a last producer writing back this cycle when the regfile passes write data through.
        nf_rs = (cnt[id_rs_i] != 2'd0) &&
                !(WB_BYPASS && (cnt[id_rs_i] == 2'd1) &&
                  wb_regwrite_i && (wb_dst_i == id_rs_i));
        nf_rt = (cnt[id_rt_i] != 2'd0) &&
                !(WB_BYPASS && (cnt[id_rt_i] == 2'd1) &&
                  wb_regwrite_i && (wb_dst_i == id_rt_i));

        haz_rs = id_valid_i && id_use_rs_i && (id_rs_i != '0) &&
                 (fwd_en_i ? lu_rs : nf_rs);
        haz_rt = id_valid_i && id_use_rt_i && (id_rt_i != '0) &&
                 (fwd_en_i ? lu_rt : nf_rt);
        stall  = haz_rs || haz_rt;
    end

    // Pipeline control, with priority: taken branch, then stall, then jump
    always_comb begin
        pc_write_o    = 1'b1;
        if_id_we_o    = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        if (ex_branch_tk_i) begin
            // Redirect wins. The stalled ID instruction is squashed anyway.
            pc_write_o    = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (stall) begin
            pc_write_o    = 1'b0;
            if_id_we_o    = 1'b0;
            id_ex_flush_o = 1'b1;
        end else if (id_jump_i) begin
            if_id_flush_o = 1'b1;
        end
    end

    // ALU operand bypass selects. MEM is the younger producer, so it takes precedence over WB.
    always_comb begin
        fwd_a_o = FWD_RF;
        fwd_b_o = FWD_RF;
        if (fwd_en_i) begin
            if (ex_rs_i != '0) begin
                if (mem_regwrite_i && (mem_dst_i == ex_rs_i)) begin
                    fwd_a_o = FWD_MEM;
                end else if (wb_regwrite_i && (wb_dst_i == ex_rs_i)) begin
                    fwd_a_o = FWD_WB;
                end
            end
            if (ex_rt_i != '0) begin
                if (mem_regwrite_i && (mem_dst_i == ex_rt_i)) begin
                    fwd_b_o = FWD_MEM;
                end else if (wb_regwrite_i && (wb_dst_i == ex_rt_i)) begin
                    fwd_b_o = FWD_WB;
                end
            end
        end
    end

    // Scoreboard events for this cycle. A squashed or stalled ID instruction does not issue.
    always_comb begin
        issue  = id_valid_i && id_regwrite_i && (id_dst_i != '0) &&
                 !stall && !ex_branch_tk_i;
        retire = wb_regwrite_i && (wb_dst_i != '0);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_cnt
            if (gi == 0) begin : g_zero
                assign cnt[gi] = 2'b00;
            end else begin : g_live
                logic [1:0] cnt_q;
                logic [1:0] cnt_d;
                logic       inc;
                logic       dec;

                // Next count: issue adds one, retire removes one, and both together cancel.
                // The count saturates at 3 and never underflows.
                always_comb begin
                    inc   = issue  && (id_dst_i == REGW'(gi));
                    dec   = retire && (wb_dst_i == REGW'(gi));
                    cnt_d = cnt_q;
                    if (inc && !dec) begin
                        if (cnt_q != 2'd3) begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end else if (dec && !inc) begin
                        if (cnt_q != 2'd0) begin
                            cnt_d = cnt_q - 2'd1;
                        end
                    end
                end

                // Pending-write counter register
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        cnt_q <= 2'd0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                assign cnt[gi] = cnt_q;
            end
        end
    endgenerate

    // Stall statistics and the sticky orphan-retire flag, next state.
    // Cycles squashed by a taken branch are not counted as stalls.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !ex_branch_tk_i && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        sb_err_d = sb_err_q || (retire && (cnt[wb_dst_i] == 2'd0));
    end

    // Status registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign sb_err_o    = sb_err_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed testbench for hazard_scoreboard_unit.
// Inputs change 1 ns after a rising edge. Outputs are sampled 1 ns later.

module tb_hazard_scoreboard_unit;

    logic        clk;
    logic        rst;
    logic        fwd_en;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_regwrite;
    logic [4:0]  id_dst;
    logic        id_jump;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic        ex_memread;
    logic [4:0]  ex_dst;
    logic        ex_branch_tk;
    logic        mem_regwrite;
    logic [4:0]  mem_dst;
    logic        wb_regwrite;
    logic [4:0]  wb_dst;
    logic        pc_write;
    logic        if_id_we;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cnt;
    logic        sb_err;

    int vecs;
    int miscmp;

    hazard_scoreboard_unit #(
        .NREG(32), .REGW(5), .CNTW(16), .WB_BYPASS(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .fwd_en_i(fwd_en),
        .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
        .id_regwrite_i(id_regwrite), .id_dst_i(id_dst), .id_jump_i(id_jump),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_memread_i(ex_memread),
        .ex_dst_i(ex_dst), .ex_branch_tk_i(ex_branch_tk),
        .mem_regwrite_i(mem_regwrite), .mem_dst_i(mem_dst),
        .wb_regwrite_i(wb_regwrite), .wb_dst_i(wb_dst),
        .pc_write_o(pc_write), .if_id_we_o(if_id_we),
        .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
        .stall_cnt_o(stall_cnt), .sb_err_o(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_regwrite = 0; id_dst = 0; id_jump = 0;
        ex_rs = 0; ex_rt = 0; ex_memread = 0; ex_dst = 0; ex_branch_tk = 0;
        mem_regwrite = 0; mem_dst = 0; wb_regwrite = 0; wb_dst = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        #1;
        vecs++; if (pc_write !== 1'b1) begin miscmp++; $display("FAIL reset pc_write got %b want 1", pc_write); end
        vecs++; if (if_id_we !== 1'b1) begin miscmp++; $display("FAIL reset if_id_we got %b want 1", if_id_we); end
        vecs++; if ({if_id_flush, id_ex_flush} !== 2'b00) begin miscmp++; $display("FAIL reset flushes got %b%b want 00", if_id_flush, id_ex_flush); end
        vecs++; if ({fwd_a, fwd_b} !== 4'b0000) begin miscmp++; $display("FAIL reset fwd got %b/%b want 00/00", fwd_a, fwd_b); end
        vecs++; if (stall_cnt !== 16'd0) begin miscmp++; $display("FAIL reset stall_cnt got %0d want 0", stall_cnt); end
        vecs++; if (sb_err !== 1'b0) begin miscmp++; $display("FAIL reset sb_err got %b want 0", sb_err); end
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        fwd_en = 1;
        // ID: lw r8
        tick(); idle(); id_valid = 1; id_regwrite = 1; id_dst = 8; #1;
        vecs++; if (pc_write !== 1'b1) begin miscmp++; $display("FAIL lu_issue pc_write got %b want 1", pc_write); end
        // EX: lw r8 ; ID: add r9,r8,r2
        tick(); idle(); ex_memread = 1; ex_dst = 8;
        id_valid = 1; id_rs = 8; id_rt = 2; id_use_rs = 1; id_use_rt = 1; id_regwrite = 1; id_dst = 9; #1;
        vecs++; if (pc_write !== 1'b0) begin miscmp++; $display("FAIL lu_stall pc_write got %b want 0", pc_write); end
        vecs++; if (if_id_we !== 1'b0) begin miscmp++; $display("FAIL lu_stall if_id_we got %b want 0", if_id_we); end
        vecs++; if (id_ex_flush !== 1'b1) begin miscmp++; $display("FAIL lu_stall id_ex_flush got %b want 1", id_ex_flush); end
        vecs++; if (if_id_flush !== 1'b0) begin miscmp++; $display("FAIL lu_stall if_id_flush got %b want 0", if_id_flush); end
        // MEM: lw r8 ; EX: bubble ; ID: add still
        tick(); idle(); mem_regwrite = 1; mem_dst = 8;
        id_valid = 1; id_rs = 8; id_rt = 2; id_use_rs = 1; id_use_rt = 1; id_regwrite = 1; id_dst = 9; #1;
        vecs++; if (pc_write !== 1'b1) begin miscmp++; $display("FAIL lu_release pc_write got %b want 1", pc_write); end
        vecs++; if (id_ex_flush !== 1'b0) begin miscmp++; $display("FAIL lu_release id_ex_flush got %b want 0", id_ex_flush); end
        // WB: lw r8 ; EX: add r9,r8,r2
        tick(); idle(); wb_regwrite = 1; wb_dst = 8; ex_rs = 8; ex_rt = 2; #1;
        vecs++; if (fwd_a !== 2'b10) begin miscmp++; $display("FAIL lu_fwd_a got %b want 10", fwd_a); end
        vecs++; if (fwd_b !== 2'b00) begin miscmp++; $display("FAIL lu_fwd_b got %b want 00", fwd_b); end
        // WB: add r9
        tick(); idle(); wb_regwrite = 1; wb_dst = 9; #1;
        vecs++; if (stall_cnt !== 16'd1) begin miscmp++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); end
        vecs++; if (sb_err !== 1'b0) begin miscmp++; $display("FAIL lu_sb_err got %b want 0", sb_err); end
        $display("test_load_use done");
    endtask

    task automatic test_back_to_back();
        fwd_en = 1;
        // ID: add r3
        tick(); idle(); id_valid = 1; id_regwrite = 1; id_dst = 3; #1;
        // EX: add r3 ; ID: sub r4,r3,r3
        tick(); idle(); ex_dst = 3;
        id_valid = 1; id_rs = 3; id_rt = 3; id_use_rs = 1; id_use_rt = 1; id_regwrite = 1; id_dst = 4; #1;
        vecs++; if (pc_write !== 1'b1) begin miscmp++; $display("FAIL b2b pc_write got %b want 1", pc_write); end
        vecs++; if (id_ex_flush !== 1'b0) begin miscmp++; $display("FAIL b2b id_ex_flush got %b want 0", id_ex_flush); end
        // MEM: add r3 ; EX: sub r4,r3,r3
        tick(); idle(); mem_regwrite = 1; mem_dst = 3; ex_rs = 3; ex_rt = 3; ex_dst = 4; #1;
        vecs++; if (fwd_a !== 2'b01) begin miscmp++; $display("FAIL b2b fwd_a got %b want 01", fwd_a); end
        vecs++; if (fwd_b !== 2'b01) begin miscmp++; $display("FAIL b2b fwd_b got %b want 01", fwd_b); end
        // r3 produced in both MEM and WB: MEM wins. WB retires r3.
        tick(); idle(); mem_regwrite = 1; mem_dst = 3; wb_regwrite = 1; wb_dst = 3; ex_rs = 3; ex_rt = 3; #1;
        vecs++; if (fwd_a !== 2'b01) begin miscmp++; $display("FAIL memwb fwd_a got %b want 01", fwd_a); end
        vecs++; if (fwd_b !== 2'b01) begin miscmp++; $display("FAIL memwb fwd_b got %b want 01", fwd_b); end
        // WB: sub r4 ; EX reads r4 and r5
        tick(); idle(); wb_regwrite = 1; wb_dst = 4; ex_rs = 4; ex_rt = 5; #1;
        vecs++; if (fwd_a !== 2'b10) begin miscmp++; $display("FAIL wbonly fwd_a got %b want 10", fwd_a); end
        vecs++; if (fwd_b !== 2'b00) begin miscmp++; $display("FAIL wbonly fwd_b got %b want 00", fwd_b); end
        tick(); idle(); #1;
        vecs++; if (sb_err !== 1'b0) begin miscmp++; $display("FAIL b2b sb_err got %b want 0", sb_err); end
        $display("test_back_to_back done");
    endtask

    task automatic test_no_forward();
        rst = 1; #1; rst = 0;
        fwd_en = 0;
        // ID: add r5
        tick(); idle(); id_valid = 1; id_regwrite = 1; id_dst = 5; #1;
        vecs++; if (pc_write !== 1'b1) begin miscmp++; $display("FAIL nf_issue pc_write got %b want 1", pc_write); end
        // ID: dependent reader of r5 (add r5 in EX)
        tick(); idle(); id_valid = 1; id_rs = 5; id_use_rs = 1; id_regwrite = 1; id_dst = 6; #1;
        vecs++; if (pc_write !== 1'b0) begin miscmp++; $display("FAIL nf_stall1 pc_write got %b want 0", pc_write); end
        // add r5 in MEM, still stalled
        tick(); idle(); id_valid = 1; id_rs = 5; id_use_rs = 1; id_regwrite = 1; id_dst = 6;
        mem_regwrite = 1; mem_dst = 5; #1;
        vecs++; if (id_ex_flush !== 1'b1) begin miscmp++; $display("FAIL nf_stall2 id_ex_flush got %b want 1", id_ex_flush); end
        // add r5 in WB: the regfile bypass releases the stall. EX operand not forwarded in this mode.
        tick(); idle(); id_valid = 1; id_rs = 5; id_use_rs = 1; id_regwrite = 1; id_dst = 6;
        wb_regwrite = 1; wb_dst = 5; ex_rs = 5; #1;
        vecs++; if (pc_write !== 1'b1) begin miscmp++; $display("FAIL nf_wb_release pc_write got %b want 1", pc_write); end
        vecs++; if (fwd_a !== 2'b00) begin miscmp++; $display("FAIL nf_fwd_off fwd_a got %b want 00", fwd_a); end
        // cnt[5] is back to 0: a fresh reader of r5 proceeds. r6 retires here.
        tick(); idle(); id_valid = 1; id_rs = 5; id_use_rs = 1; wb_regwrite = 1; wb_dst = 6; #1;
        vecs++; if (pc_write !== 1'b1) begin miscmp++; $display("FAIL nf_cnt5_zero pc_write got %b want 1", pc_write); end
        vecs++; if (stall_cnt !== 16'd2) begin miscmp++; $display("FAIL nf_stall_cnt got %0d want 2", stall_cnt); end
        tick(); idle(); id_valid = 1; id_rt = 6; id_use_rt = 1; #1;
        vecs++; if (pc_write !== 1'b1) begin miscmp++; $display("FAIL nf_cnt6_zero pc_write got %b want 1", pc_write); end
        vecs++; if (sb_err !== 1'b0) begin miscmp++; $display("FAIL nf_sb_err got %b want 0", sb_err); end
        $display("test_no_forward done");
    endtask

    task automatic test_branch_over_stall();
        fwd_en = 1;
        tick(); idle(); ex_memread = 1; ex_dst = 8; ex_branch_tk = 1;
        id_valid = 1; id_rs = 8; id_use_rs = 1; id_regwrite = 1; id_dst = 10; #1;
        vecs++; if (pc_write !== 1'b1) begin miscmp++; $display("FAIL br pc_write got %b want 1", pc_write); end
        vecs++; if (if_id_flush !== 1'b1) begin miscmp++; $display("FAIL br if_id_flush got %b want 1", if_id_flush); end
        vecs++; if (id_ex_flush !== 1'b1) begin miscmp++; $display("FAIL br id_ex_flush got %b want 1", id_ex_flush); end
        // r10 must not have been issued: a no-forward reader of r10 proceeds
        fwd_en = 0;
        tick(); idle(); id_valid = 1; id_rs = 10; id_use_rs = 1; #1;
        vecs++; if (pc_write !== 1'b1) begin miscmp++; $display("FAIL br_noissue pc_write got %b want 1", pc_write); end
        vecs++; if (stall_cnt !== 16'd2) begin miscmp++; $display("FAIL br_stall_cnt got %0d want 2", stall_cnt); end
        $display("test_branch_over_stall done");
    endtask

    task automatic test_jump();
        fwd_en = 1;
        tick(); idle(); id_valid = 1; id_jump = 1; #1;
        vecs++; if ({pc_write, if_id_flush, id_ex_flush} !== 3'b110) begin miscmp++; $display("FAIL jump pc/ifid/idex got %b want 110", {pc_write, if_id_flush, id_ex_flush}); end
        tick(); idle(); id_valid = 1; id_jump = 1; id_rt = 8; id_use_rt = 1; ex_memread = 1; ex_dst = 8; #1;
        vecs++; if ({pc_write, if_id_flush, id_ex_flush} !== 3'b001) begin miscmp++; $display("FAIL jump_stall pc/ifid/idex got %b want 001", {pc_write, if_id_flush, id_ex_flush}); end
        tick(); idle(); #1;
        vecs++; if (stall_cnt !== 16'd3) begin miscmp++; $display("FAIL jump_stall_cnt got %0d want 3", stall_cnt); end
        $display("test_jump done");
    endtask

    task automatic test_r0();
        fwd_en = 1;
        tick(); idle(); ex_memread = 1; ex_dst = 0;
        id_valid = 1; id_use_rs = 1; id_use_rt = 1; id_regwrite = 1; id_dst = 0;
        mem_regwrite = 1; mem_dst = 0; wb_regwrite = 1; wb_dst = 0; #1;
        vecs++; if (pc_write !== 1'b1) begin miscmp++; $display("FAIL r0 pc_write got %b want 1", pc_write); end
        vecs++; if ({fwd_a, fwd_b} !== 4'b0000) begin miscmp++; $display("FAIL r0 fwd got %b/%b want 00/00", fwd_a, fwd_b); end
        fwd_en = 0;
        tick(); idle(); id_valid = 1; id_use_rs = 1; id_use_rt = 1; #1;
        vecs++; if (pc_write !== 1'b1) begin miscmp++; $display("FAIL r0_nf pc_write got %b want 1", pc_write); end
        vecs++; if (sb_err !== 1'b0) begin miscmp++; $display("FAIL r0 sb_err got %b want 0", sb_err); end
        $display("test_r0 done");
    endtask

    task automatic test_sb_err_and_reset();
        fwd_en = 0;
        tick(); idle(); wb_regwrite = 1; wb_dst = 7; #1;
        vecs++; if (sb_err !== 1'b0) begin miscmp++; $display("FAIL err_pre sb_err got %b want 0", sb_err); end
        tick(); idle(); #1;
        vecs++; if (sb_err !== 1'b1) begin miscmp++; $display("FAIL err_set sb_err got %b want 1", sb_err); end
        tick(); idle(); #1;
        vecs++; if (sb_err !== 1'b1) begin miscmp++; $display("FAIL err_sticky sb_err got %b want 1", sb_err); end
        // issue r12, then a reader stalls
        tick(); idle(); id_valid = 1; id_regwrite = 1; id_dst = 12; #1;
        tick(); idle(); id_valid = 1; id_rs = 12; id_use_rs = 1; #1;
        vecs++; if (pc_write !== 1'b0) begin miscmp++; $display("FAIL rst_pre_stall pc_write got %b want 0", pc_write); end
        tick(); #1;
        vecs++; if (stall_cnt !== 16'd4) begin miscmp++; $display("FAIL rst_pre stall_cnt got %0d want 4", stall_cnt); end
        rst = 1; #1;
        vecs++; if (stall_cnt !== 16'd0) begin miscmp++; $display("FAIL rst_mid stall_cnt got %0d want 0", stall_cnt); end
        vecs++; if (sb_err !== 1'b0) begin miscmp++; $display("FAIL rst_mid sb_err got %b want 0", sb_err); end
        vecs++; if (pc_write !== 1'b1) begin miscmp++; $display("FAIL rst_mid pc_write got %b want 1", pc_write); end
        rst = 0;
        tick(); #1;
        vecs++; if (pc_write !== 1'b1) begin miscmp++; $display("FAIL rst_after pc_write got %b want 1", pc_write); end
        $display("test_sb_err_and_reset done");
    endtask

    initial begin
        vecs = 0;
        miscmp = 0;
        rst = 1;
        fwd_en = 0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        test_reset();
        test_load_use();
        test_back_to_back();
        test_no_forward();
        test_branch_over_stall();
        test_jump();
        test_r0();
        test_sb_err_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
